// File: rtl/bcd_cnt_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_cnt_ctrl -- two-digit BCD up-counter with run/pause/clear control FSM.
//
// A start in IDLE captures a two-digit BCD terminal value (digits above 9 are
// clamped to 9) and counts q up from 00 once every DIV clocks.
//
// Default build (single shot): when q reaches the terminal value the FSM
// passes through DONE for one cycle (done=1) and returns to IDLE. q holds its
// final value.
//
// Build with BCD_CTRL_AUTORELOAD_EN defined: reaching the terminal value
// pulses done for one cycle. The next tick reloads q to 00 and counting
// continues in RUN until clear or reset. DONE is then only reached by a start
// with a terminal value of 00.
//
// Parameters:
//   DIV    clocks per count tick, 1..255
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-low reset
//   start  run request, sampled only in IDLE
//   pause  level; freezes the count (RUN -> HOLD) while high
//   clear  abort back to IDLE with q=00; highest priority
//   limit  terminal value {tens, units}, captured on an accepted start
//   q      registered BCD count {tens, units}
//   busy   high in RUN and HOLD (registered)
//   done   one-cycle pulse when q reaches the terminal value (registered)
// -----------------------------------------------------------------------------
module bcd_cnt_ctrl #(
  parameter int unsigned DIV = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [7:0] limit,
  output logic [7:0] q,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] PRESC_LAST = 8'(DIV - 1);

  state_t     state, state_nxt;
  logic [7:0] q_nxt;
  logic [7:0] lim_r, lim_nxt;
  logic [7:0] presc, presc_nxt;
  logic       hit_nxt;
  logic       busy_nxt, done_nxt;
  logic [7:0] q_inc;
  logic [7:0] lim_cap;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // BCD increment of both digits; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens, units;
    tens  = v[7:4];
    units = v[3:0];
    if (units >= 4'd9) begin
      units = 4'd0;
      tens  = (tens >= 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

  assign q_inc   = bcd_inc(q);
  assign lim_cap = {clamp_digit(limit[7:4]), clamp_digit(limit[3:0])};

  // NOTE: every variable written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    lim_nxt   = lim_r;
    presc_nxt = presc;
    hit_nxt   = 1'b0;

    if (clear) begin
      state_nxt = IDLE;
      q_nxt     = 8'h00;
      presc_nxt = 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            lim_nxt   = lim_cap;
            q_nxt     = 8'h00;
            presc_nxt = 8'd0;
            // A terminal value of 00 is reached immediately.
            state_nxt = (lim_cap == 8'h00) ? DONE : RUN;
          end
        end

        RUN: begin
          if (pause) begin
            // Pause wins over the tick; the prescaler phase is preserved.
            state_nxt = HOLD;
          end else if (presc == PRESC_LAST) begin
            presc_nxt = 8'd0;
`ifdef BCD_CTRL_AUTORELOAD_EN
            if (q == lim_r) begin
              q_nxt = 8'h00;
            end else begin
              q_nxt   = q_inc;
              hit_nxt = (q_inc == lim_r);
            end
`else
            q_nxt = q_inc;
            if (q_inc == lim_r) state_nxt = DONE;
`endif
          end else begin
            presc_nxt = presc + 8'd1;
          end
        end

        HOLD: begin
          if (!pause) state_nxt = RUN;
        end

        DONE: begin
          state_nxt = IDLE;
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  // Status flags are registered from the next state so they change only on
  // the clock edge and never glitch through state decoding.
  assign busy_nxt = (state_nxt == RUN) || (state_nxt == HOLD);
  assign done_nxt = (state_nxt == DONE) || hit_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      q     <= 8'h00;
      lim_r <= 8'h00;
      presc <= 8'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      lim_r <= lim_nxt;
      presc <= presc_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

endmodule
